// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default sizes for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;
    function automatic owner_e other(input owner_e o);
        return o == OWN_IF ? OWN_LS : OWN_IF;
    endfunction
endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: response watchdog, expire on the TIMEOUT_CYC-th enabled cycle; 0 disables it
module mem_arb_wdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    if (TIMEOUT_CYC == 0) begin : g_off
        assign expire = 1'b0;
    end else begin : g_on
        localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
        logic [CW-1:0] cnt;
        always_ff @(posedge clk or posedge rst)
            if (rst) cnt <= '0;
            else if (clr) cnt <= '0;
            else if (en) cnt <= cnt + 1'b1;
        assign expire = en && cnt == CW'(TIMEOUT_CYC - 1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight
// ARB_ROUND_ROBIN_EN selects alternating grants on contention; default is LS-over-IF priority
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    arb_state_e state;
    owner_e     owner, last_served, winner;
    logic       expire, in_wait, done;

    assign in_wait = state == WAIT_RESP;
    // winner is only latched when someone requests; last_served is a don't-care fill
`ifdef ARB_ROUND_ROBIN_EN
    assign winner = if_req && ls_req ? other(last_served) : ls_req ? OWN_LS : if_req ? OWN_IF : last_served;
`else
    assign winner = ls_req ? OWN_LS : if_req ? OWN_IF : last_served;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            last_served <= OWN_LS;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
        end else begin
            case (state)
                IDLE: if (if_req || ls_req) begin
                    state       <= ISSUE;
                    owner       <= winner;
                    last_served <= winner;
                    mem_req     <= 1'b1;
                    mem_we      <= winner == OWN_LS && ls_we;
                    mem_addr    <= winner == OWN_LS ? ls_addr : if_addr;
                    mem_wdata   <= winner == OWN_LS ? ls_wdata : '0;
                    mem_be      <= winner == OWN_LS ? ls_be : '1;
                end
                ISSUE: if (mem_gnt) begin
                    state   <= WAIT_RESP;
                    mem_req <= 1'b0;
                end
                WAIT_RESP: if (mem_rvalid || expire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == ISSUE && mem_gnt),
        .en     (in_wait),
        .expire (expire)
    );

    // a real response arriving on the expiry cycle takes precedence over the bus error
    assign done      = in_wait && (mem_rvalid || expire);
    assign if_rvalid = done && owner == OWN_IF;
    assign ls_rvalid = done && owner == OWN_LS;
    assign bus_err   = in_wait && expire && !mem_rvalid;
    assign if_rdata  = if_rvalid && mem_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid && mem_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a scripted memory model
module tb_mem_port_arbiter;
    localparam int TO = 4;

    typedef struct {
        logic        ls;
        logic [31:0] d;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_be = '0;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_be      (ls_be),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic ls, input logic [31:0] d, input logic err);
        sb.push_back('{ls, d, err});
    endtask

    // memory side of one transaction; the requester is already asserting in IDLE
    task automatic serve(input logic own_ls, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int gd, input int rd, input logic rsp, input logic [31:0] data);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mem_req && n < 20);
        chk("req_latency", 96'(n), 96'd1);
        for (int k = 0; k <= gd; k++) begin
            chk("mem_fields", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, we, be, addr, wdata});
            if (k < gd) begin
                @(posedge clk); #1;
            end
        end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("req_drop_after_gnt", mem_req, 0);
        if (rsp) begin
            repeat (rd - 1) begin
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = data;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else begin
            for (int k = 1; k < TO; k++) begin
                chk("wdog_quiet", {if_rvalid, ls_rvalid, bus_err}, 0);
                @(posedge clk); #1;
            end
            chk("wdog_expire", {if_rvalid, ls_rvalid, bus_err}, {~own_ls, own_ls, 1'b1});
            @(posedge clk); #1;
        end
        if (own_ls) ls_req = 1'b0;
        else if_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && (if_rvalid || ls_rvalid)) begin
            if (sb.size() == 0) chk("unexpected_rsp", {if_rvalid, ls_rvalid}, 0);
            else begin
                e = sb.pop_front();
                chk("rsp_owner", {if_rvalid, ls_rvalid}, {~e.ls, e.ls});
                chk("rsp_rdata", {if_rdata, ls_rdata}, e.ls ? {32'h0, e.d} : {e.d, 32'h0});
                chk("rsp_bus_err", bus_err, e.err);
            end
        end else if (!rst && bus_err) chk("orphan_bus_err", bus_err, 0);
    end

    initial begin
        #2;
        chk("reset_outs", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rvalid, ls_rvalid, bus_err}, 0);
        chk("reset_rdata", {if_rdata, ls_rdata}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // contention: both requesters re-raise after every completion
        if_addr = 32'h0000_0400;
        ls_we   = 1'b1;
        ls_be   = 4'hf;
        for (int i = 0; i < 4; i++) begin
            logic e_ls;
`ifdef ARB_ROUND_ROBIN_EN
            e_ls = i[0];
`else
            e_ls = 1'b1;
`endif
            ls_addr  = 32'h3000 + 32'(i * 4);
            ls_wdata = 32'hCAFE_0000 + 32'(i);
            if_req   = 1'b1;
            ls_req   = 1'b1;
            push(e_ls, 32'h5000 + 32'(i), 1'b0);
            if (e_ls) serve(1'b1, 1'b1, ls_addr, ls_wdata, 4'hf, 0, 1, 1'b1, 32'h5000 + 32'(i));
            else serve(1'b0, 1'b0, if_addr, 32'h0, 4'hf, 0, 1, 1'b1, 32'h5000 + 32'(i));
        end
        push(1'b0, 32'h0000_6000, 1'b0);
        serve(1'b0, 1'b0, if_addr, 32'h0, 4'hf, 1, 3, 1'b1, 32'h0000_6000);

        // plain fetch
        if_addr = 32'h0000_0100;
        if_req  = 1'b1;
        push(1'b0, 32'hDEAD_BEEF, 1'b0);
        serve(1'b0, 1'b0, 32'h100, 32'h0, 4'hf, 0, 2, 1'b1, 32'hDEAD_BEEF);

        // store with delayed grant
        ls_we    = 1'b1;
        ls_addr  = 32'h0000_2000;
        ls_wdata = 32'h1234_5678;
        ls_be    = 4'b0011;
        ls_req   = 1'b1;
        push(1'b1, 32'h0000_00A5, 1'b0);
        serve(1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 3, 2, 1'b1, 32'h0000_00A5);

        // watchdog expiry on a load and on a fetch
        ls_we    = 1'b0;
        ls_addr  = 32'h0000_2400;
        ls_wdata = 32'h0;
        ls_be    = 4'hf;
        ls_req   = 1'b1;
        push(1'b1, 32'h0, 1'b1);
        serve(1'b1, 1'b0, 32'h2400, 32'h0, 4'hf, 0, 1, 1'b0, 32'h0);
        if_addr = 32'h0000_0200;
        if_req  = 1'b1;
        push(1'b0, 32'h0, 1'b1);
        serve(1'b0, 1'b0, 32'h200, 32'h0, 4'hf, 2, 1, 1'b0, 32'h0);

        // response lands on the expiry cycle itself
        if_req = 1'b1;
        push(1'b0, 32'h7777_0001, 1'b0);
        serve(1'b0, 1'b0, 32'h200, 32'h0, 4'hf, 0, TO, 1'b1, 32'h7777_0001);

        // reset while waiting for the response
        ls_addr = 32'h0000_2800;
        ls_req  = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rvalid, ls_rvalid, bus_err}, 0);
        ls_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        #1;
        chk("rst_late_rsp", {if_rvalid, ls_rvalid, bus_err}, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        chk("rst_idle", mem_req, 0);
        if_addr = 32'h0000_0300;
        if_req  = 1'b1;
        push(1'b0, 32'h0BAD_F00D, 1'b0);
        serve(1'b0, 1'b0, 32'h300, 32'h0, 4'hf, 1, 2, 1'b1, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", mem_req, 0);
        chk("sb_empty", 96'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
